// File: rtl/console_uart_tx.sv
// console_uart_tx: buffers console bytes in a small FIFO and sends each one as an 8N1 UART frame on tx.
module console_uart_tx #(
  parameter int XLEN = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          console_we,
  input  logic [XLEN-1:0]               console_wdata,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic [15:0] baud;
  logic push, pop, full, bit_end, unused_bits;
  assign full = fifo_count == FULL;
  assign push = console_we && !full;
  assign pop = state == IDLE && fifo_count != '0;
  assign bit_end = baud == LAST;
  assign busy = state != IDLE || fifo_count != '0;
  assign unused_bits = ^console_wdata[XLEN-1:8];
  always_ff @(posedge clk)
    if (push) mem[wptr] <= console_wdata[7:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      overflow <= overflow | (console_we & full);
    end
  end
  // tx is loaded with the level of the upcoming bit, so it changes on the edge that enters that bit
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      tx <= 1'b1;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else begin
      baud <= (state == IDLE || bit_end) ? '0 : baud + 16'd1;
      case (state)
        IDLE: begin
          tx <= !pop;
          if (pop) begin
            shift <= mem[rptr];
            state <= START;
          end
        end
        START: if (bit_end) begin
          state <= DATA;
          bit_idx <= '0;
          tx <= shift[0];
        end
        DATA: if (bit_end) begin
          shift <= shift >> 1;
          bit_idx <= bit_idx + 3'd1;
          tx <= (bit_idx == 3'd7) ? 1'b1 : shift[1];
          if (bit_idx == 3'd7) state <= STOP;
        end
        STOP: if (bit_end) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_console_uart_tx.sv
// tb_console_uart_tx: table-driven and scoreboard check of console_uart_tx with a bit-decoding tx monitor.
module tb_console_uart_tx;
  localparam int C = 4;
  localparam int D = 4;
  logic clk = 0, reset = 1, console_we = 0;
  logic [31:0] console_wdata = '0;
  logic tx, busy, overflow;
  logic [2:0] fifo_count;
  int errors = 0, checks = 0;
  logic [7:0] exp_q[$];
  int cyc = 0, frames = 0, last_start = 0, gap = 0, pos = 0;
  logic in_frame = 0;
  logic [7:0] rx = '0;
  typedef struct { logic [31:0] wdata; logic [7:0] exp; } vec_t;
  vec_t vecs[6];
  console_uart_tx #(.XLEN(32), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .console_we(console_we), .console_wdata(console_wdata),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [31:0] d);
    console_we = 1;
    console_wdata = d;
    @(posedge clk); #1;
    console_we = 0;
  endtask
  task automatic wait_idle(input int lim, output int n);
    n = 0;
    while (busy && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask
  // decodes frames mid-bit and compares each byte with the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (reset) in_frame = 0;
    else if (!in_frame) begin
      if (tx == 1'b0) begin
        in_frame = 1;
        pos = 0;
        gap = cyc - last_start;
        last_start = cyc;
      end
    end else begin
      pos++;
      if (pos == C/2) chk("start_bit", tx, 0);
      for (int i = 0; i < 8; i++) if (pos == C*(i+1) + C/2) rx[i] = tx;
      if (pos == 9*C + C/2) chk("stop_bit", tx, 1);
      if (pos == 10*C - 1) begin
        in_frame = 0;
        frames++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %02h expected none", rx);
        end else chk("rx_byte", rx, exp_q.pop_front());
      end
    end
  end
  initial begin
    int n, fr;
    vecs[0] = '{32'h0000_0041, 8'h41};
    vecs[1] = '{32'h0000_0000, 8'h00};
    vecs[2] = '{32'h0000_00FF, 8'hFF};
    vecs[3] = '{32'hDEAD_BE7A, 8'h7A};
    vecs[4] = '{32'h0000_0081, 8'h81};
    vecs[5] = '{32'hFFFF_FF3C, 8'h3C};
    repeat (3) @(posedge clk);
    #1 reset = 0;
    repeat (20) begin
      @(posedge clk); #1;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_count", fifo_count, 0);
    end
    foreach (vecs[k]) begin
      exp_q.push_back(vecs[k].exp);
      wr(vecs[k].wdata);
      chk("count_after_push", fifo_count, 1);
      @(posedge clk); #1;
      chk("tx_falls_after_pop", tx, 0);
      chk("count_after_pop", fifo_count, 0);
      wait_idle(200, n);
      chk("frame_cycles", n, 40);
      chk("idle_tx", tx, 1);
    end
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    wr(32'h55);
    wr(32'hAA);
    wait_idle(300, n);
    chk("b2b_span", n, 81);
    chk("b2b_gap", gap, 41);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 5; i++) wr(32'h30 + i);
    chk("ovf_count_full", fifo_count, 4);
    chk("ovf_not_yet", overflow, 0);
    wr(32'h35);
    chk("ovf_set", overflow, 1);
    chk("ovf_count_held", fifo_count, 4);
    wait_idle(1000, n);
    chk("ovf_sticky", overflow, 1);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    wr(32'h00);
    wr(32'h01);
    repeat (12) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    exp_q.delete();
    fr = frames;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("mrst_tx", tx, 1);
    chk("mrst_count", fifo_count, 0);
    chk("mrst_overflow", overflow, 0);
    chk("mrst_busy", busy, 0);
    repeat (100) @(posedge clk);
    #1;
    chk("mrst_no_frames", frames, fr);
    chk("mrst_tx_idle", tx, 1);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/console_uart_tx.md
Name: console_uart_tx

Overview:
- Downstream consumer of the core's console port (console_we / console_wdata).
- Buffers console bytes in a small FIFO and serializes each as an 8N1 UART frame on a single tx pin.
- Lets firmware printf output reach a physical serial line on FPGA builds; the simulation $write path is unaffected.
- Sits at top level beside bbq and is driven directly by its console outputs.

Parameters:
XLEN, 32, width of console_wdata; only bits [7:0] are transmitted
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535
FIFO_DEPTH, 16, byte entries in the buffer; power of two, 2..256

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
console_we  input  1  one-cycle write strobe from the core
console_wdata  input  XLEN  console data; [7:0] is the character, upper bits ignored
tx  output  1  UART serial out, idle high
busy  output  1  high while the FIFO is non-empty or a frame is in flight
overflow  output  1  sticky; set when a write is dropped because the FIFO is full
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes currently buffered

Behaviour:
- Reset is synchronous and active-high; clk and reset are the only clock/reset.
- Reset values: tx=1, busy=0, overflow=0, fifo_count=0, FSM in IDLE, read/write pointers 0, bit and baud counters 0.
- Reset asserted mid-frame: tx is 1 on the cycle after the reset edge, the frame is abandoned and the FIFO is flushed. No partial frame resumes.
- Push:
  - On a cycle with console_we=1 and fifo_count<FIFO_DEPTH, console_wdata[7:0] is written at wptr, wptr wraps modulo FIFO_DEPTH, and fifo_count increments next cycle.
- Full:
  - If console_we=1 and fifo_count==FIFO_DEPTH (registered value), the byte is dropped and overflow sets to 1 next cycle.
  - This holds even if a pop occurs in the same cycle.
  - overflow clears only on reset.
- Simultaneous push and pop with a non-full FIFO: both happen and fifo_count is unchanged.
- Pointers are log2(FIFO_DEPTH) bits; full vs empty is decided by fifo_count, not by pointer compare.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If fifo_count!=0: pop the byte at rptr into an 8-bit shift register, advance rptr, clear the baud counter, go to START next cycle.
  - Otherwise stay in IDLE.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first.
  - At the end of each bit period, shift right and increment the bit index.
  - After bit 7's period, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame timing:
  - tx falls on the cycle after the pop.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly one IDLE cycle (tx=1), so the frame period is 10*CLKS_PER_BIT+1.
- Baud counter: counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, is 16 bits wide, and is held at 0 in IDLE.
- tx is registered (driven from a flop) so there are no glitches.
- busy = (state!=IDLE) || (fifo_count!=0), registered-equivalent (derived only from flops).
- A write arriving on the same cycle as the IDLE pop decision is not visible to that decision; it is popped no earlier than the next IDLE cycle.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Reset check:
  - Stimulus: hold reset 3 cycles, release, idle 20 cycles.
  - Required: tx=1, busy=0, overflow=0, fifo_count=0 throughout.
- Single byte:
  - Stimulus: write 0x41 ('A') once.
  - Required: fifo_count=1 for one cycle; then tx samples at 4-cycle spacing are 0,1,0,0,0,0,0,1,0,1 (start, LSB-first 0x41, stop); busy drops to 0 on the cycle after the stop bit ends; total of 40 cycles with tx framed.
- Back-to-back bytes:
  - Stimulus: write 0x55 then 0xAA on consecutive cycles.
  - Required: two frames, the second start bit beginning exactly 41 cycles after the first; the bench-decoded bytes are 0x55, 0xAA in order.
- Overflow:
  - Stimulus: write 6 bytes 0x30..0x35 on consecutive cycles.
  - Required: first byte popped immediately, next 4 buffered (fifo_count reaches 4), 6th byte 0x35 dropped; overflow=1 from the cycle after the drop and stays high; transmitted sequence is 0x30..0x34.
- Upper bits ignored:
  - Stimulus: write console_wdata=0xDEADBE7A.
  - Required: the transmitted byte is 0x7A.
- Reset mid-frame:
  - Stimulus: write 0x00 and 0x01, then assert reset for 1 cycle during the DATA state of the first frame.
  - Required: tx=1 the cycle after reset, fifo_count=0, no further frames, overflow=0.
